if_prefetch_queue: RTL and testbench
====================================

# if_prefetch_queue

Parametrised instruction-fetch stage with a prefetch queue, sitting between the PC/redirect logic and the IF/ID pipeline register. It issues sequential single-word reads to the shared RAM port, buffers returned {pc, inst} pairs in a DEPTH-entry FIFO, and presents one instruction per cycle to decode. It adds a prefetch queue, an internal PC, and clean redirect handling with discard of in-flight reads.

## Interface
- ADDR_W, 32, PC and RAM address width.
- INST_W, 32, instruction width.
- DEPTH, 4, queue entries; power of two, at least 2.
- RESET_PC, 0, fetch PC after reset.
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- rdy  in  1  global enable; low freezes all state and forces ram_re_o low.
- redirect_i  in  1  flush plus new fetch target (branch/jump resolved).
- redirect_pc_i  in  ADDR_W  target PC, sampled when redirect_i is high.
- stall_i  in  1  decode hold; output register keeps its value.
- valid_o  out  1  pc_o/inst_o hold a real instruction.
- pc_o  out  ADDR_W  PC of the presented instruction; 0 when not valid.
- inst_o  out  INST_W  instruction; 0 (bubble) when not valid.
- count_o  out  $clog2(DEPTH+1)  queue occupancy.
- ram_re_o  out  1  read request; single-cycle, combinational.
- ram_addr_o  out  ADDR_W  read address; equals fetch_pc.
- ram_busy_i  in  1  RAM port is serving another master.
- ram_done_i  in  1  one-cycle pulse; ram_data_i is valid.
- ram_data_i  in  INST_W  read data.

## Operation
- Internal state: fetch_pc, req_pc, the FIFO (rd_ptr, wr_ptr, count), the output register, and the FSM.
- FSM states:
  - IDLE: no read in flight.
  - WAIT: read in flight.
  - DISCARD: read in flight whose data must be dropped.
- Read issue:
  - ram_re_o = rdy & !rst & state==IDLE & count<DEPTH & !ram_busy_i & !redirect_i.
  - On issue: req_pc<=fetch_pc, fetch_pc<=fetch_pc+4, go to WAIT.
- WAIT with ram_done_i: push {req_pc, ram_data_i}, go to IDLE. The occupancy rule keeps at most one read in flight, so the push never overflows.
- DISCARD with ram_done_i: drop the data, go to IDLE.
- Output register, when stall_i is low:
  - Queue non-empty: pop the head into pc_o/inst_o and set valid_o=1.
  - Queue empty: load a bubble (valid_o=0, pc_o=0, inst_o=0).
- Output register, when stall_i is high: holds its value. Pushes continue.
- Redirect (priority over stall_i and ram_done_i):
  - Queue emptied; count=0.
  - Output register loads a bubble.
  - fetch_pc<=redirect_pc_i.
  - WAIT without ram_done_i goes to DISCARD. WAIT with ram_done_i in the same cycle drops the data and goes to IDLE. DISCARD stays in DISCARD unless ram_done_i.
- Push and pop in the same cycle: count is unchanged; pointers wrap modulo DEPTH.
- rdy low: no register changes, including FIFO, FSM and outputs.
- Reset: state=IDLE, fetch_pc=RESET_PC, count=0, pointers=0, valid_o=0, pc_o=0, inst_o=0.
- A reset mid-read leaves a late ram_done_i arriving in IDLE; it is ignored.

## Timing
- Redirect in cycle N: the first request to redirect_pc_i is issued in cycle N+1 if the RAM is free and no read is outstanding.
- Read issued in cycle N, ram_done_i in cycle M: the entry is in the queue after edge M. Without bypass it is visible on the outputs after edge M+1, provided stall_i was low in cycle M+1.
- Peak throughput is bounded by the RAM latency: one read in flight at a time.
- count_o updates on the same edge as the push/pop.

## Configuration
- IFQ_BYPASS_EN defined:
  - When ram_done_i arrives in WAIT with the queue empty, stall_i low and no redirect, the data loads directly into the output register and the push is skipped.
  - Saves one cycle of fetch latency.
- IFQ_BYPASS_EN undefined: every instruction passes through the queue (minimum one extra cycle).

## Test plan
- Reset with RESET_PC=0x100 and a RAM with 2-cycle latency -> ram_addr_o 0x100, 0x104, 0x108 in order. valid_o pc_o sequence is 0x100, 0x104, 0x108, with the matching data.
- Hold stall_i high for 10 cycles with DEPTH=4 -> count_o saturates at 4, ram_re_o stays low, and pc_o stays constant. After release, 4 consecutive valid instructions appear without gaps.
- redirect_i with redirect_pc_i=0x200 while a read to 0x10C is in flight -> the 0x10C data is dropped (no valid_o carries 0x10C), and the next fetch address is 0x200.
- redirect_i in the same cycle as ram_done_i -> data dropped, state IDLE, next ram_addr_o=redirect_pc_i one cycle later.
- ram_busy_i high for 5 cycles -> no ram_re_o during that time, and outputs are bubbles (inst_o=0, pc_o=0) once the queue drains.
- rdy low for 3 cycles mid-read, with ram_done_i held off -> all outputs and count_o unchanged. Resumes correctly when rdy returns high. Cover both with and without IFQ_BYPASS_EN, checking the 1-cycle latency difference.

Source files
------------

// File: rtl/if_prefetch_queue_if.sv
// Fetch-stage bundle for if_prefetch_queue: the redirect/stall/decode side
// plus the single-word read channel to the shared RAM port.
// master: the prefetch queue itself. slave: the surrounding pipeline and RAM.
interface if_prefetch_queue_if #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32,
    parameter int DEPTH  = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic              rdy;
    logic              redirect_i;
    logic [ADDR_W-1:0] redirect_pc_i;
    logic              stall_i;
    logic              valid_o;
    logic [ADDR_W-1:0] pc_o;
    logic [INST_W-1:0] inst_o;
    logic [CNT_W-1:0]  count_o;
    logic              ram_re_o;
    logic [ADDR_W-1:0] ram_addr_o;
    logic              ram_busy_i;
    logic              ram_done_i;
    logic [INST_W-1:0] ram_data_i;

    modport master (
        input  rdy,
        input  redirect_i,
        input  redirect_pc_i,
        input  stall_i,
        output valid_o,
        output pc_o,
        output inst_o,
        output count_o,
        output ram_re_o,
        output ram_addr_o,
        input  ram_busy_i,
        input  ram_done_i,
        input  ram_data_i
    );

    modport slave (
        output rdy,
        output redirect_i,
        output redirect_pc_i,
        output stall_i,
        input  valid_o,
        input  pc_o,
        input  inst_o,
        input  count_o,
        input  ram_re_o,
        input  ram_addr_o,
        output ram_busy_i,
        output ram_done_i,
        output ram_data_i
    );
endinterface

// File: rtl/if_prefetch_queue.sv
// Instruction-fetch stage with a DEPTH-entry prefetch queue.
// Issues sequential single-word reads (one in flight at a time), queues the
// returned {pc, inst} pairs and presents one instruction per cycle to decode.
// A redirect flushes the queue and discards any read still in flight.
// Optional feature: define IFQ_BYPASS_EN to let a returning read go straight
// into the output register when the queue is empty and decode is not stalled.
module if_prefetch_queue #(
    parameter int                ADDR_W   = 32,
    parameter int                INST_W   = 32,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    if_prefetch_queue_if.master io_fetch
);
    localparam int              PTR_W   = $clog2(DEPTH);
    localparam int              CNT_W   = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] L_DEPTH = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DISCARD
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [ADDR_W-1:0] r_fetchPc;
    logic [ADDR_W-1:0] r_reqPc;

    logic [ADDR_W-1:0] r_memPc   [DEPTH];
    logic [INST_W-1:0] r_memInst [DEPTH];
    logic [PTR_W-1:0]  r_rdPtr;
    logic [PTR_W-1:0]  r_wrPtr;
    logic [CNT_W-1:0]  r_count;

    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic [INST_W-1:0] r_inst;

    logic              w_empty;
    logic              w_full;
    logic              w_issue;
    logic              w_waitDone;
    logic              w_bypass;
    logic              w_push;
    logic              w_pop;

    // Control decode and next-state: issue gating, push/pop/bypass and FSM moves
    always_comb begin
        w_nextState = r_state;
        w_empty     = (r_count == '0);
        w_full      = (r_count == L_DEPTH);
        w_issue     = io_fetch.rdy & ~rst & (r_state == S_IDLE) & ~w_full
                      & ~io_fetch.ram_busy_i & ~io_fetch.redirect_i;
        w_waitDone  = (r_state == S_WAIT) & io_fetch.ram_done_i & ~io_fetch.redirect_i;
`ifdef IFQ_BYPASS_EN
        w_bypass    = w_waitDone & w_empty & ~io_fetch.stall_i;
`else
        w_bypass    = 1'b0;
`endif
        w_push      = w_waitDone & ~w_bypass;
        w_pop       = ~io_fetch.redirect_i & ~io_fetch.stall_i & ~w_empty;

        case (r_state)
            S_IDLE: begin
                if (w_issue) begin
                    w_nextState = S_WAIT;
                end
            end
            S_WAIT: begin
                if (io_fetch.redirect_i) begin
                    w_nextState = io_fetch.ram_done_i ? S_IDLE : S_DISCARD;
                end else if (io_fetch.ram_done_i) begin
                    w_nextState = S_IDLE;
                end
            end
            S_DISCARD: begin
                if (io_fetch.ram_done_i) begin
                    w_nextState = S_IDLE;
                end
            end
            default: begin
                w_nextState = S_IDLE;
            end
        endcase
    end

    // FSM state register; frozen while rdy is low
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else if (io_fetch.rdy) begin
            r_state <= w_nextState;
        end
    end

    // Fetch PC advances on every issued read and jumps on redirect
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fetchPc <= RESET_PC;
            r_reqPc   <= '0;
        end else if (io_fetch.rdy) begin
            if (io_fetch.redirect_i) begin
                r_fetchPc <= io_fetch.redirect_pc_i;
            end else if (w_issue) begin
                r_reqPc   <= r_fetchPc;
                r_fetchPc <= r_fetchPc + PC_STEP;
            end
        end
    end

    // Queue storage; written only when a returned read is kept
    always_ff @(posedge clk) begin
        if (io_fetch.rdy && !rst && w_push) begin
            r_memPc[r_wrPtr]   <= r_reqPc;
            r_memInst[r_wrPtr] <= io_fetch.ram_data_i;
        end
    end

    // Queue pointers and occupancy; redirect empties the queue
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rdPtr <= '0;
            r_wrPtr <= '0;
            r_count <= '0;
        end else if (io_fetch.rdy) begin
            if (io_fetch.redirect_i) begin
                r_rdPtr <= '0;
                r_wrPtr <= '0;
                r_count <= '0;
            end else begin
                if (w_push) begin
                    r_wrPtr <= r_wrPtr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rdPtr <= r_rdPtr + PTR_W'(1);
                end
                if (w_push && !w_pop) begin
                    r_count <= r_count + CNT_W'(1);
                end else if (!w_push && w_pop) begin
                    r_count <= r_count - CNT_W'(1);
                end
            end
        end
    end

    // Output register: bubble on redirect, hold on stall, else pop/bypass/bubble
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
        end else if (io_fetch.rdy) begin
            if (io_fetch.redirect_i) begin
                r_valid <= 1'b0;
                r_pc    <= '0;
                r_inst  <= '0;
            end else if (!io_fetch.stall_i) begin
                if (!w_empty) begin
                    r_valid <= 1'b1;
                    r_pc    <= r_memPc[r_rdPtr];
                    r_inst  <= r_memInst[r_rdPtr];
                end else if (w_bypass) begin
                    r_valid <= 1'b1;
                    r_pc    <= r_reqPc;
                    r_inst  <= io_fetch.ram_data_i;
                end else begin
                    r_valid <= 1'b0;
                    r_pc    <= '0;
                    r_inst  <= '0;
                end
            end
        end
    end

    assign io_fetch.valid_o    = r_valid;
    assign io_fetch.pc_o       = r_pc;
    assign io_fetch.inst_o     = r_inst;
    assign io_fetch.count_o    = r_count;
    assign io_fetch.ram_re_o   = w_issue;
    assign io_fetch.ram_addr_o = r_fetchPc;
endmodule

// File: tb/tb_if_prefetch_queue.sv
// Directed testbench for if_prefetch_queue (RESET_PC=0x100, DEPTH=4).
// A small RAM responder returns 0xC0DE_0000 | addr[15:0] after a
// configurable latency; every expected value below is hand-derived.
// Build with +define+IFQ_BYPASS_EN to exercise the bypass configuration.
module tb_if_prefetch_queue;
    // Issue-to-visible latency on valid_o for an empty queue
`ifdef IFQ_BYPASS_EN
    localparam int          FETCH_LAT   = 3;
    localparam logic        FROZEN_V    = 1'b0;
    localparam logic [31:0] FROZEN_PC   = 32'h0;
    localparam logic [31:0] FROZEN_INST = 32'h0;
`else
    localparam int          FETCH_LAT   = 4;
    localparam logic        FROZEN_V    = 1'b1;
    localparam logic [31:0] FROZEN_PC   = 32'h100;
    localparam logic [31:0] FROZEN_INST = 32'hC0DE0100;
`endif

    logic clk;
    logic rst;
    int   assertCount;
    int   failCount;
    int   ramLat;
    logic ramHold;
    logic ramPending;
    int   ramCnt;
    logic [31:0] ramAddr;

    if_prefetch_queue_if #(.ADDR_W(32), .INST_W(32), .DEPTH(4)) fetchBus ();

    if_prefetch_queue #(
        .ADDR_W  (32),
        .INST_W  (32),
        .DEPTH   (4),
        .RESET_PC(32'h100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .io_fetch(fetchBus.master)
    );

    // Free-running clock, 10 time units per cycle
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // RAM responder: captures a request at the falling edge, answers later
    initial begin
        ramPending = 1'b0;
        ramCnt     = 0;
        ramAddr    = '0;
        fetchBus.ram_done_i = 1'b0;
        fetchBus.ram_data_i = '0;
        forever begin
            @(posedge clk);
            #1;
            fetchBus.ram_done_i = 1'b0;
            if (ramPending) begin
                if (ramCnt > 1) begin
                    ramCnt = ramCnt - 1;
                end else if (!ramHold) begin
                    fetchBus.ram_done_i = 1'b1;
                    fetchBus.ram_data_i = 32'hC0DE0000 | (ramAddr & 32'h0000FFFF);
                    ramPending = 1'b0;
                end
            end
            @(negedge clk);
            if (rst) begin
                ramPending = 1'b0;
            end else if (fetchBus.ram_re_o) begin
                ramPending = 1'b1;
                ramCnt     = ramLat;
                ramAddr    = fetchBus.ram_addr_o;
            end
        end
    end

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic resetDut(input int lat);
        ramLat   = lat;
        ramHold  = 1'b0;
        rst      = 1'b1;
        fetchBus.rdy           = 1'b1;
        fetchBus.redirect_i    = 1'b0;
        fetchBus.redirect_pc_i = '0;
        fetchBus.stall_i       = 1'b0;
        fetchBus.ram_busy_i    = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset;
        ramLat  = 2;
        ramHold = 1'b0;
        rst     = 1'b1;
        fetchBus.rdy           = 1'b1;
        fetchBus.redirect_i    = 1'b0;
        fetchBus.redirect_pc_i = '0;
        fetchBus.stall_i       = 1'b0;
        fetchBus.ram_busy_i    = 1'b0;
        step();
        step();
        assertCount++;
        if (fetchBus.valid_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_valid: got %0b expected 0", fetchBus.valid_o);
        end
        assertCount++;
        if (fetchBus.pc_o !== 32'h0 || fetchBus.inst_o !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL reset_bubble: got pc %h inst %h expected 0/0", fetchBus.pc_o, fetchBus.inst_o);
        end
        assertCount++;
        if (fetchBus.count_o !== 3'd0) begin
            failCount++;
            $display("[TB] FAIL reset_count: got %0d expected 0", fetchBus.count_o);
        end
        assertCount++;
        if (fetchBus.ram_re_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL reset_re: got %0b expected 0", fetchBus.ram_re_o);
        end
        assertCount++;
        if (fetchBus.ram_addr_o !== 32'h100) begin
            failCount++;
            $display("[TB] FAIL reset_addr: got %h expected 00000100", fetchBus.ram_addr_o);
        end
    endtask

    task automatic test_fetch_order;
        logic [31:0] issAddr [3];
        logic [31:0] vPc     [3];
        logic [31:0] vInst   [3];
        int          vCyc    [3];
        int          issCnt;
        int          vCnt;
        issCnt = 0;
        vCnt   = 0;
        resetDut(2);
        for (int i = 0; i < 12; i++) begin
            if (fetchBus.ram_re_o === 1'b1) begin
                if (issCnt < 3) issAddr[issCnt] = fetchBus.ram_addr_o;
                issCnt++;
            end
            if (fetchBus.valid_o === 1'b1) begin
                if (vCnt < 3) begin
                    vPc[vCnt]   = fetchBus.pc_o;
                    vInst[vCnt] = fetchBus.inst_o;
                    vCyc[vCnt]  = i;
                end
                vCnt++;
            end
            step();
        end
        assertCount++;
        if (issCnt != 4) begin
            failCount++;
            $display("[TB] FAIL order_issue_count: got %0d expected 4", issCnt);
        end
        assertCount++;
        if (vCnt != 3) begin
            failCount++;
            $display("[TB] FAIL order_valid_count: got %0d expected 3", vCnt);
        end
        for (int k = 0; k < 3; k++) begin
            if (k < issCnt) begin
                assertCount++;
                if (issAddr[k] !== 32'h100 + 32'(4 * k)) begin
                    failCount++;
                    $display("[TB] FAIL order_addr%0d: got %h expected %h", k, issAddr[k], 32'h100 + 32'(4 * k));
                end
            end
            if (k < vCnt) begin
                assertCount++;
                if (vPc[k] !== 32'h100 + 32'(4 * k)) begin
                    failCount++;
                    $display("[TB] FAIL order_pc%0d: got %h expected %h", k, vPc[k], 32'h100 + 32'(4 * k));
                end
                assertCount++;
                if (vInst[k] !== 32'hC0DE0100 + 32'(4 * k)) begin
                    failCount++;
                    $display("[TB] FAIL order_inst%0d: got %h expected %h", k, vInst[k], 32'hC0DE0100 + 32'(4 * k));
                end
            end
        end
        if (vCnt > 0) begin
            assertCount++;
            if (vCyc[0] != FETCH_LAT) begin
                failCount++;
                $display("[TB] FAIL order_latency: got %0d expected %0d", vCyc[0], FETCH_LAT);
            end
        end
    endtask

    task automatic test_stall;
        int reLate;
        int maxCnt;
        reLate = 0;
        maxCnt = 0;
        resetDut(1);
        fetchBus.stall_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (int'(fetchBus.count_o) > maxCnt) maxCnt = int'(fetchBus.count_o);
            if (i >= 8 && fetchBus.ram_re_o !== 1'b0) reLate++;
            step();
        end
        assertCount++;
        if (fetchBus.count_o !== 3'd4 || maxCnt != 4) begin
            failCount++;
            $display("[TB] FAIL stall_count: got %0d (max %0d) expected 4", fetchBus.count_o, maxCnt);
        end
        assertCount++;
        if (reLate != 0 || fetchBus.ram_re_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL stall_re_full: got %0d requests expected 0", reLate);
        end
        assertCount++;
        if (fetchBus.valid_o !== 1'b0 || fetchBus.pc_o !== 32'h0) begin
            failCount++;
            $display("[TB] FAIL stall_hold: got valid %0b pc %h expected 0/0", fetchBus.valid_o, fetchBus.pc_o);
        end
        fetchBus.stall_i = 1'b0;
        for (int j = 0; j < 4; j++) begin
            step();
            assertCount++;
            if (fetchBus.valid_o !== 1'b1 || fetchBus.pc_o !== 32'h100 + 32'(4 * j)) begin
                failCount++;
                $display("[TB] FAIL stall_drain%0d: got valid %0b pc %h expected 1/%h", j, fetchBus.valid_o, fetchBus.pc_o, 32'h100 + 32'(4 * j));
            end
            assertCount++;
            if (fetchBus.inst_o !== 32'hC0DE0100 + 32'(4 * j)) begin
                failCount++;
                $display("[TB] FAIL stall_inst%0d: got %h expected %h", j, fetchBus.inst_o, 32'hC0DE0100 + 32'(4 * j));
            end
        end
    endtask

    task automatic test_redirect_same_cycle;
        int          firstIdx;
        logic [31:0] firstPc;
        logic [31:0] firstInst;
        int          stale;
        firstIdx  = -1;
        firstPc   = '0;
        firstInst = '0;
        stale     = 0;
        resetDut(2);
        step();
        step();
        fetchBus.redirect_i    = 1'b1;
        fetchBus.redirect_pc_i = 32'h300;
        step();
        fetchBus.redirect_i = 1'b0;
        #1;
        assertCount++;
        if (fetchBus.count_o !== 3'd0 || fetchBus.valid_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rdsame_flush: got count %0d valid %0b expected 0/0", fetchBus.count_o, fetchBus.valid_o);
        end
        assertCount++;
        if (fetchBus.ram_re_o !== 1'b1 || fetchBus.ram_addr_o !== 32'h300) begin
            failCount++;
            $display("[TB] FAIL rdsame_next_req: got re %0b addr %h expected 1/00000300", fetchBus.ram_re_o, fetchBus.ram_addr_o);
        end
        for (int i = 0; i < 8; i++) begin
            if (fetchBus.valid_o === 1'b1) begin
                if (fetchBus.pc_o === 32'h100) stale++;
                if (firstIdx < 0) begin
                    firstIdx  = i;
                    firstPc   = fetchBus.pc_o;
                    firstInst = fetchBus.inst_o;
                end
            end
            step();
        end
        assertCount++;
        if (stale != 0) begin
            failCount++;
            $display("[TB] FAIL rdsame_dropped: got %0d stale instructions expected 0", stale);
        end
        assertCount++;
        if (firstPc !== 32'h300 || firstInst !== 32'hC0DE0300 || firstIdx != FETCH_LAT) begin
            failCount++;
            $display("[TB] FAIL rdsame_target: got pc %h inst %h at %0d expected 00000300 c0de0300 at %0d", firstPc, firstInst, firstIdx, FETCH_LAT);
        end
    endtask

    task automatic test_redirect_inflight;
        int          firstIdx;
        logic [31:0] firstPc;
        int          stale;
        firstIdx = -1;
        firstPc  = '0;
        stale    = 0;
        resetDut(2);
        fetchBus.redirect_i    = 1'b1;
        fetchBus.redirect_pc_i = 32'h10C;
        #1;
        assertCount++;
        if (fetchBus.ram_re_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rdfly_gate: got re %0b expected 0", fetchBus.ram_re_o);
        end
        step();
        fetchBus.redirect_i = 1'b0;
        #1;
        assertCount++;
        if (fetchBus.ram_re_o !== 1'b1 || fetchBus.ram_addr_o !== 32'h10C) begin
            failCount++;
            $display("[TB] FAIL rdfly_req10c: got re %0b addr %h expected 1/0000010c", fetchBus.ram_re_o, fetchBus.ram_addr_o);
        end
        step();
        fetchBus.redirect_i    = 1'b1;
        fetchBus.redirect_pc_i = 32'h200;
        step();
        fetchBus.redirect_i = 1'b0;
        #1;
        assertCount++;
        if (fetchBus.ram_re_o !== 1'b0 || fetchBus.ram_addr_o !== 32'h200) begin
            failCount++;
            $display("[TB] FAIL rdfly_discard: got re %0b addr %h expected 0/00000200", fetchBus.ram_re_o, fetchBus.ram_addr_o);
        end
        step();
        assertCount++;
        if (fetchBus.ram_re_o !== 1'b1 || fetchBus.ram_addr_o !== 32'h200) begin
            failCount++;
            $display("[TB] FAIL rdfly_req200: got re %0b addr %h expected 1/00000200", fetchBus.ram_re_o, fetchBus.ram_addr_o);
        end
        for (int i = 0; i < 8; i++) begin
            if (fetchBus.valid_o === 1'b1) begin
                if (fetchBus.pc_o === 32'h10C) stale++;
                if (firstIdx < 0) begin
                    firstIdx = i;
                    firstPc  = fetchBus.pc_o;
                end
            end
            step();
        end
        assertCount++;
        if (stale != 0) begin
            failCount++;
            $display("[TB] FAIL rdfly_dropped: got %0d instructions at 0000010c expected 0", stale);
        end
        assertCount++;
        if (firstPc !== 32'h200 || firstIdx != FETCH_LAT) begin
            failCount++;
            $display("[TB] FAIL rdfly_target: got pc %h at %0d expected 00000200 at %0d", firstPc, firstIdx, FETCH_LAT);
        end
    endtask

    task automatic test_busy;
        resetDut(1);
        step();
        step();
        step();
        fetchBus.ram_busy_i = 1'b1;
        #1;
        for (int i = 0; i < 5; i++) begin
            assertCount++;
            if (fetchBus.ram_re_o !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL busy_re%0d: got %0b expected 0", i, fetchBus.ram_re_o);
            end
            if (i == 4) begin
                assertCount++;
                if (fetchBus.valid_o !== 1'b0 || fetchBus.pc_o !== 32'h0 || fetchBus.inst_o !== 32'h0) begin
                    failCount++;
                    $display("[TB] FAIL busy_bubble: got valid %0b pc %h inst %h expected 0/0/0", fetchBus.valid_o, fetchBus.pc_o, fetchBus.inst_o);
                end
                assertCount++;
                if (fetchBus.count_o !== 3'd0) begin
                    failCount++;
                    $display("[TB] FAIL busy_count: got %0d expected 0", fetchBus.count_o);
                end
            end
            step();
        end
        fetchBus.ram_busy_i = 1'b0;
        #1;
        assertCount++;
        if (fetchBus.ram_re_o !== 1'b1 || fetchBus.ram_addr_o !== 32'h108) begin
            failCount++;
            $display("[TB] FAIL busy_resume: got re %0b addr %h expected 1/00000108", fetchBus.ram_re_o, fetchBus.ram_addr_o);
        end
    endtask

    task automatic test_rdy;
        int          firstIdx;
        logic [31:0] firstPc;
        logic [31:0] firstInst;
        firstIdx  = -1;
        firstPc   = '0;
        firstInst = '0;
        resetDut(2);
        for (int i = 0; i < 4; i++) step();
        fetchBus.rdy = 1'b0;
        ramHold      = 1'b1;
        #1;
        assertCount++;
        if (fetchBus.ram_re_o !== 1'b0) begin
            failCount++;
            $display("[TB] FAIL rdy_re: got %0b expected 0", fetchBus.ram_re_o);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            assertCount++;
            if (fetchBus.valid_o !== FROZEN_V || fetchBus.pc_o !== FROZEN_PC || fetchBus.inst_o !== FROZEN_INST) begin
                failCount++;
                $display("[TB] FAIL rdy_freeze%0d: got valid %0b pc %h inst %h expected %0b/%h/%h", i, fetchBus.valid_o, fetchBus.pc_o, fetchBus.inst_o, FROZEN_V, FROZEN_PC, FROZEN_INST);
            end
            assertCount++;
            if (fetchBus.count_o !== 3'd0 || fetchBus.ram_re_o !== 1'b0) begin
                failCount++;
                $display("[TB] FAIL rdy_idle%0d: got count %0d re %0b expected 0/0", i, fetchBus.count_o, fetchBus.ram_re_o);
            end
        end
        fetchBus.rdy = 1'b1;
        ramHold      = 1'b0;
        step();
        for (int i = 0; i < 6; i++) begin
            if (fetchBus.valid_o === 1'b1 && firstIdx < 0) begin
                firstIdx  = i;
                firstPc   = fetchBus.pc_o;
                firstInst = fetchBus.inst_o;
            end
            step();
        end
        assertCount++;
        if (firstPc !== 32'h104 || firstInst !== 32'hC0DE0104 || firstIdx != FETCH_LAT - 2) begin
            failCount++;
            $display("[TB] FAIL rdy_resume: got pc %h inst %h at %0d expected 00000104 c0de0104 at %0d", firstPc, firstInst, firstIdx, FETCH_LAT - 2);
        end
    endtask

    // Runs each scenario in turn, then prints the summary
    initial begin
        assertCount = 0;
        failCount   = 0;
        ramLat      = 2;
        ramHold     = 1'b0;
        rst         = 1'b1;
        fetchBus.rdy           = 1'b1;
        fetchBus.redirect_i    = 1'b0;
        fetchBus.redirect_pc_i = '0;
        fetchBus.stall_i       = 1'b0;
        fetchBus.ram_busy_i    = 1'b0;
        $display("[TB] if_prefetch_queue directed test start");
        test_reset();
        test_fetch_order();
        test_stall();
        test_redirect_same_cycle();
        test_redirect_inflight();
        test_busy();
        test_rdy();
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end
endmodule
